// File: rtl/tcm_arbiter_pkg.sv
// ============================================================================
// Module   : tcm_arbiter_pkg
// Brief    : FSM state encoding and master-index constants for tcm_arbiter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package tcm_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    localparam logic C_MASTER0 = 1'b0;
    localparam logic C_MASTER1 = 1'b1;

endpackage

`default_nettype wire

// File: rtl/tcm_arbiter_rr_arbiter2.sv
// ============================================================================
// Module   : rr_arbiter2
// Brief    : Two-way round-robin grant; stateless, the history lives in the caller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module rr_arbiter2
    import tcm_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = 2'b00;
        unique case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            // On a tie the master that did not win last time goes next.
            2'b11:   grant_o = (last_grant_i == C_MASTER1) ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/tcm_arbiter.sv
// ============================================================================
// Module   : tcm_arbiter
// Brief    : Round-robin sharing of one TCM SRAM port between two masters.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tcm_arbiter
    import tcm_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDRW      = 14
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    m0_req_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [ADDRW-1:0]        m0_addr_i,
    input  logic [DATA_WIDTH-1:0]   m0_data_i,
    output logic [DATA_WIDTH-1:0]   m0_data_o,
    output logic                    m0_ready_o,
    input  logic                    m1_req_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [ADDRW-1:0]        m1_addr_i,
    input  logic [DATA_WIDTH-1:0]   m1_data_i,
    output logic [DATA_WIDTH-1:0]   m1_data_o,
    output logic                    m1_ready_o,
    output logic                    sram_en_o,
    output logic                    sram_we_o,
    output logic [DATA_WIDTH/8-1:0] sram_be_o,
    output logic [ADDRW-1:0]        sram_addr_o,
    output logic [DATA_WIDTH-1:0]   sram_data_o,
    input  logic [DATA_WIDTH-1:0]   sram_data_i,
    input  logic                    sram_ready_i
);

    localparam int BEW = DATA_WIDTH / 8;

    state_e                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic                  en_q, en_d;
    logic                  we_q, we_d;
    logic [BEW-1:0]        be_q, be_d;
    logic [ADDRW-1:0]      addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
    logic [DATA_WIDTH-1:0] m0_data_q, m0_data_d, m1_data_q, m1_data_d;
    logic [1:0]            grant;
    logic                  winner;

    rr_arbiter2 u_rr (
        .req_i        ({m1_req_i, m0_req_i}),
        .last_grant_i (last_grant_q),
        .grant_o      (grant)
    );

    assign winner = grant[1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            last_grant_q <= C_MASTER1;
            en_q         <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            m0_ready_q   <= 1'b0;
            m1_ready_q   <= 1'b0;
            m0_data_q    <= '0;
            m1_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            en_q         <= en_d;
            we_q         <= we_d;
            be_q         <= be_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            m0_ready_q   <= m0_ready_d;
            m1_ready_q   <= m1_ready_d;
            m0_data_q    <= m0_data_d;
            m1_data_q    <= m1_data_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        en_d         = 1'b0;
        we_d         = we_q;
        be_d         = be_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        m0_ready_d   = 1'b0;
        m1_ready_d   = 1'b0;
        m0_data_d    = m0_data_q;
        m1_data_d    = m1_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (m0_req_i || m1_req_i) begin
                    last_grant_d = winner;
                    en_d         = 1'b1;
                    we_d         = (winner == C_MASTER1) ? m1_we_i   : m0_we_i;
                    be_d         = (winner == C_MASTER1) ? m1_be_i   : m0_be_i;
                    addr_d       = (winner == C_MASTER1) ? m1_addr_i : m0_addr_i;
                    wdata_d      = (winner == C_MASTER1) ? m1_data_i : m0_data_i;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                // last_grant_q still names the master that owns this transaction.
                if (sram_ready_i) begin
                    if (last_grant_q == C_MASTER1) begin
                        m1_ready_d = 1'b1;
                        m1_data_d  = sram_data_i;
                    end else begin
                        m0_ready_d = 1'b1;
                        m0_data_d  = sram_data_i;
                    end
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign sram_en_o   = en_q;
    assign sram_we_o   = we_q;
    assign sram_be_o   = be_q;
    assign sram_addr_o = addr_q;
    assign sram_data_o = wdata_q;
    assign m0_ready_o  = m0_ready_q;
    assign m1_ready_o  = m1_ready_q;
    assign m0_data_o   = m0_data_q;
    assign m1_data_o   = m1_data_q;

endmodule

`default_nettype wire
